// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: glyph table,
// pin polarity levels and the all-dark segment pattern.
package sevenseg_pkg;

    // Board pins are active-low: driving 0 lights a segment or selects an anode.
    localparam logic LVL_ON  = 1'b0;
    localparam logic LVL_OFF = 1'b1;

    // Active-low {CG..CA} pattern with every segment dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex nibble to lit segments, active-high, bit order {CG,CF,CE,CD,CC,CB,CA}.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational glyph decoder: nibble + decimal point to active-low pin levels.
// A blanked digit drives every segment and the DP dark.
module sevenseg_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    // Glyph lookup with polarity inversion; blank overrides everything.
    always_comb begin
        seg_n = SEG_OFF;
        dp_n  = LVL_OFF;
        if (!blank) begin
            seg_n = ~hex2seg(nibble);
            dp_n  = dp ? LVL_ON : LVL_OFF;
        end
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment scan driver. A prescaler divides the clock into
// digit slots; new display data is staged and only swapped in on a frame
// boundary so a frame never mixes old and new digits. Each slot begins with
// a short anode-off guard window to suppress ghosting.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk_100,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic                    CA,
    output logic                    CB,
    output logic                    CC,
    output logic                    CD,
    output logic                    CE,
    output logic                    CF,
    output logic                    CG,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [PCNT_W-1:0] PCNT_GUARD = PCNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tick;
    logic                  frame_end;

    // Staging and displayed data
    logic [DATA_W-1:0]     stage_data_q, stage_data_d;
    logic [NUM_DIGITS-1:0] stage_dp_q, stage_dp_d;
    logic                  pending_q, pending_d;
    logic [DATA_W-1:0]     disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;

    // Registered pin drivers
    logic                  load_ack_q, load_ack_d;
    logic                  frame_start_q, frame_start_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    // Per-digit view of the displayed data
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_blank;
    logic [6:0]            dec_seg_n;
    logic                  dec_dp_n;
    logic                  cur_blank;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign nib[gi] = disp_data_q[4*gi +: 4];
    end

    // Prescaler and digit index; a frame ends on the tick of the last digit.
    always_comb begin
        tick      = (pcnt_q == PCNT_LAST);
        frame_end = tick && (idx_q == IDX_LAST);
        pcnt_d    = tick ? '0 : pcnt_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Load handshake: stage mid-frame, swap at the frame boundary. A load
    // landing exactly on the boundary goes straight to the display and
    // supersedes anything still waiting in stage.
    always_comb begin
        stage_data_d = stage_data_q;
        stage_dp_d   = stage_dp_q;
        pending_d    = pending_q;
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        load_ack_d   = 1'b0;
        if (frame_end) begin
            if (load) begin
                disp_data_d = data_in;
                disp_dp_d   = dp_in;
                pending_d   = 1'b0;
                load_ack_d  = 1'b1;
            end else if (pending_q) begin
                disp_data_d = stage_data_q;
                disp_dp_d   = stage_dp_q;
                pending_d   = 1'b0;
                load_ack_d  = 1'b1;
            end
        end else if (load) begin
            stage_data_d = data_in;
            stage_dp_d   = dp_in;
            pending_d    = 1'b1;
        end
    end

    // Blanking: scan from the top nibble down, remembering whether any
    // nonzero nibble has been seen; digit 0 always stays visible to blank_lz.
    always_comb begin
        logic seen_nz;
        seen_nz     = 1'b0;
        digit_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nz        = seen_nz | (|disp_data_q[4*i +: 4]);
            digit_blank[i] = ~digit_en[i] | ((i != 0) & blank_lz & ~seen_nz);
        end
    end

    assign cur_blank = digit_blank[idx_q];

    sevenseg_decoder u_decoder (
        .nibble (nib[idx_q]),
        .dp     (disp_dp_q[idx_q]),
        .blank  (cur_blank),
        .seg_n  (dec_seg_n),
        .dp_n   (dec_dp_n)
    );

    // Pin values for the current slot; the anode waits out the guard window
    // while the segments already carry the new glyph.
    always_comb begin
        frame_start_d = (pcnt_q == '0) && (idx_q == '0);
        seg_d         = dec_seg_n;
        dp_d          = dec_dp_n;
        an_d          = {NUM_DIGITS{LVL_OFF}};
        if (!cur_blank && (pcnt_q >= PCNT_GUARD)) begin
            an_d[idx_q] = LVL_ON;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            pcnt_q        <= '0;
            idx_q         <= '0;
            stage_data_q  <= '0;
            stage_dp_q    <= '0;
            pending_q     <= 1'b0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            an_q          <= {NUM_DIGITS{LVL_OFF}};
            seg_q         <= SEG_OFF;
            dp_q          <= LVL_OFF;
        end else begin
            pcnt_q        <= pcnt_d;
            idx_q         <= idx_d;
            stage_data_q  <= stage_data_d;
            stage_dp_q    <= stage_dp_d;
            pending_q     <= pending_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
    assign AN          = an_q;
    assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
    assign DP          = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: a cycle-count reference model checks every
// output each cycle, table vectors check glyphs per digit, and hand-written
// sequences cover ack counting, boundary bypass and mid-slot reset.
module tb_sevenseg_scan_driver;

    localparam int N     = 4;
    localparam int R     = 8;
    localparam int G     = 2;
    localparam int FRAME = N * R;

    // Lit segments per hex value, {CG..CA}.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk_100 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = 4'hF;
    logic        blank_lz = 1'b0;
    logic        load = 1'b0;
    logic        load_ack, frame_start;
    logic        CA, CB, CC, CD, CE, CF, CG, DP;
    logic [3:0]  AN;
    logic [7:0]  obs;

    assign obs = {DP, CG, CF, CE, CD, CC, CB, CA};

    sevenseg_scan_driver #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .GUARD_CYCLES (G)
    ) dut (
        .clk_100     (clk_100),
        .reset       (reset),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .blank_lz    (blank_lz),
        .load        (load),
        .load_ack    (load_ack),
        .frame_start (frame_start),
        .CA (CA), .CB (CB), .CC (CC), .CD (CD),
        .CE (CE), .CF (CF), .CG (CG), .DP (DP),
        .AN          (AN)
    );

    always #5 clk_100 = ~clk_100;

    int total = 0;
    int bad   = 0;

    // Reference model: time since reset release plus what is shown/waiting.
    int          s = 0;
    logic [15:0] m_disp = '0, m_stage = '0;
    logic [3:0]  m_dpd = '0, m_dps = '0;
    logic        m_pend = 1'b0;

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic            blz;
        logic [3:0][7:0] seg;   // expected {DP,CG..CA} for digits 3..0
        logic [3:0]      lit;   // digits whose anode must go low
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        int         pc, ix;
        logic       bnd, lit;
        logic [3:0] an_e;
        logic [7:0] seg_e;
        logic       ack_e, fs_e;
        @(posedge clk_100);
        if (reset) begin
            s = 0; m_disp = '0; m_stage = '0; m_dpd = '0; m_dps = '0; m_pend = 1'b0;
            an_e = 4'hF; seg_e = 8'hFF; ack_e = 1'b0; fs_e = 1'b0;
        end else begin
            pc  = s % R;
            ix  = (s / R) % N;
            bnd = ((s % FRAME) == FRAME - 1);
            lit = digit_en[ix] && !(blank_lz && ix > 0 && (m_disp >> (4 * ix)) == 16'h0);
            an_e = 4'hF;
            if (lit && pc >= G) an_e[ix] = 1'b0;
            seg_e = lit ? {~m_dpd[ix], ~GLYPH[m_disp[4*ix +: 4]]} : 8'hFF;
            fs_e  = ((s % FRAME) == 0);
            ack_e = bnd && (m_pend || load);
            if (bnd && load) begin
                m_disp = data_in; m_dpd = dp_in; m_pend = 1'b0;
            end else if (load) begin
                m_stage = data_in; m_dps = dp_in; m_pend = 1'b1;
            end else if (bnd && m_pend) begin
                m_disp = m_stage; m_dpd = m_dps; m_pend = 1'b0;
            end
            s++;
        end
        #1;
        check("cycle{an,seg,ack,fs}", {18'h0, AN, obs, load_ack, frame_start},
              {18'h0, an_e, seg_e, ack_e, fs_e});
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        data_in = d; dp_in = p; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!load_ack && n < 2 * FRAME + 4) begin step(); n++; end
        check("ack_seen", {31'h0, load_ack}, 32'h1);
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin step(); n++; end while (!frame_start && n < 2 * FRAME + 4);
        check("fs_seen", {31'h0, frame_start}, 32'h1);
    endtask

    task automatic wait_an(input logic [3:0] pat, input string name);
        int n = 0;
        while (AN !== pat && n < 2 * FRAME) begin step(); n++; end
        check(name, {28'h0, AN}, {28'h0, pat});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         fs_cnt, an_low, acks, idx;
        logic [3:0] mask;

        vecs[0] = '{16'h12AF, 4'b0100, 4'hF, 1'b0, {8'hF9, 8'h24, 8'h88, 8'h8E}, 4'hF};
        vecs[1] = '{16'h0030, 4'b0000, 4'hF, 1'b1, {8'hFF, 8'hFF, 8'hB0, 8'hC0}, 4'b0011};
        vecs[2] = '{16'h0000, 4'b0000, 4'hF, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'b0001};
        vecs[3] = '{16'h12AF, 4'b0100, 4'b1011, 1'b0, {8'hF9, 8'h24, 8'h88, 8'h8E}, 4'b1011};
        vecs[4] = '{16'h00F0, 4'b0001, 4'hF, 1'b0, {8'hC0, 8'hC0, 8'h8E, 8'h40}, 4'hF};

        // Reset and release, idle scan of the zero display
        repeat (3) step();
        check("reset_an", {28'h0, AN}, 32'hF);
        check("reset_seg", {24'h0, obs}, 32'hFF);
        reset = 1'b0;
        step();
        check("first_fs", {31'h0, frame_start}, 32'h1);
        fs_cnt = 0; an_low = 0;
        repeat (64) begin
            step();
            fs_cnt += int'(frame_start);
            if (AN != 4'hF) an_low++;
            if (AN == 4'b1110) check("idle_zero_glyph", {24'h0, obs}, 32'hC0);
        end
        check("fs_per_64", fs_cnt, 2);
        check("an_low_per_64", an_low, 48);

        // Table vectors: load mid-frame, then inspect one whole frame
        for (int v = 0; v < 5; v++) begin
            digit_en = vecs[v].en;
            blank_lz = vecs[v].blz;
            repeat (3 + 2 * v) step();
            pulse_load(vecs[v].data, vecs[v].dp);
            wait_ack();
            wait_fs();
            mask = '0;
            for (int k = 0; k < FRAME; k++) begin
                if (AN != 4'hF) begin
                    idx = 0;
                    for (int d = 0; d < N; d++) if (!AN[d]) idx = d;
                    check("an_onehot", $countones(~AN), 1);
                    check($sformatf("vec%0d_seg_d%0d", v, idx), {24'h0, obs}, {24'h0, vecs[v].seg[idx]});
                    mask[idx] = 1'b1;
                end
                step();
            end
            check($sformatf("vec%0d_lit", v), {28'h0, mask}, {28'h0, vecs[v].lit});
        end

        // Two loads within one frame yield a single ack and the later value
        digit_en = 4'hF; blank_lz = 1'b0;
        wait_fs();
        repeat (3) step();
        pulse_load(16'h1111, 4'h0);
        repeat (5) step();
        pulse_load(16'h2222, 4'h0);
        acks = 0;
        repeat (2 * FRAME) begin step(); acks += int'(load_ack); end
        check("double_load_acks", acks, 1);
        wait_an(4'b1110, "double_load_an0");
        check("double_load_glyph", {24'h0, obs}, 32'hA4);

        // Load on the boundary tick bypasses stage and drops the older staged value
        wait_fs();
        while (s % FRAME != 10) step();
        pulse_load(16'h9999, 4'h0);
        while (s % FRAME != FRAME - 1) step();
        pulse_load(16'h5678, 4'h0);
        check("bypass_ack", {31'h0, load_ack}, 32'h1);
        step();
        check("bypass_fs", {31'h0, frame_start}, 32'h1);
        check("bypass_glyph", {24'h0, obs}, 32'h80);
        acks = 0;
        repeat (2 * FRAME) begin step(); acks += int'(load_ack); end
        check("bypass_no_extra_ack", acks, 0);

        // Reset mid-slot with a pending load
        wait_fs();
        repeat (R + 3) step();
        pulse_load(16'hABCD, 4'hF);
        repeat (2) step();
        reset = 1'b1;
        step();
        check("rst_an", {28'h0, AN}, 32'hF);
        check("rst_ack", {31'h0, load_ack}, 32'h0);
        step();
        reset = 1'b0;
        acks = 0;
        repeat (2 * FRAME) begin step(); acks += int'(load_ack); end
        check("rst_no_ack", acks, 0);
        wait_an(4'b1110, "rst_an0");
        check("rst_disp_zero", {24'h0, obs}, 32'hC0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            load    = ($urandom_range(0, 15) == 0);
            data_in = 16'($urandom);
            dp_in   = 4'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                digit_en = 4'($urandom);
                blank_lz = 1'($urandom);
            end
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 399) == 0) data_in = 16'h0000;
            step();
        end
        load = 1'b0; reset = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
